// File: rtl/apb_modport.sv
// APB subsystem: command-port master bridge driving two zero-wait
// 256x8 register slaves over a shared internal APB bus.
module apb_slave #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          psel_i,
    input  logic          penable_i,
    input  logic          pwrite_i,
    input  logic [AW-2:0] idx_i,
    input  logic [DW-1:0] pwdata_i,
    output logic [DW-1:0] prdata_o,
    output logic          pready_o
);
    localparam int DEPTH = 2 ** (AW - 1);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (psel_i && penable_i && pwrite_i) begin
            mem_q[idx_i] <= pwdata_i;
        end
    end

    assign pready_o = psel_i & penable_i;
    // Unselected slave drives zero so the master can simply OR the buses.
    assign prdata_o = psel_i ? mem_q[idx_i] : '0;
endmodule

module apb_modport #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          transfer,
    input  logic          read_write,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    input  logic [AW-1:0] apb_read_paddr,
    output logic [DW-1:0] apb_read_data_out
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic          pwrite_q, pwrite_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          psel1, psel2, penable, pready;
    logic          pready1, pready2;
    logic [DW-1:0] prdata, prdata1, prdata2;

    assign penable = (state_q == ACCESS);
    assign psel1   = (state_q != IDLE) & ~paddr_q[AW-1];
    assign psel2   = (state_q != IDLE) & paddr_q[AW-1];
    assign pready  = pready1 | pready2;
    assign prdata  = prdata1 | prdata2;

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE:    if (transfer) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready) state_d = transfer ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
        // Command is latched only on entry to SETUP and held through ACCESS.
        if (state_d == SETUP) begin
            pwrite_d = ~read_write;
            paddr_d  = read_write ? apb_read_paddr : apb_write_paddr;
            pwdata_d = apb_write_data;
        end
        if (penable && pready && !pwrite_q) begin
            rdata_d = prdata;
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign apb_read_data_out = rdata_q;

    apb_slave #(.AW(AW), .DW(DW)) u_slave1 (
        .pclk      (pclk),
        .presetn   (presetn),
        .psel_i    (psel1),
        .penable_i (penable),
        .pwrite_i  (pwrite_q),
        .idx_i     (paddr_q[AW-2:0]),
        .pwdata_i  (pwdata_q),
        .prdata_o  (prdata1),
        .pready_o  (pready1)
    );

    apb_slave #(.AW(AW), .DW(DW)) u_slave2 (
        .pclk      (pclk),
        .presetn   (presetn),
        .psel_i    (psel2),
        .penable_i (penable),
        .pwrite_i  (pwrite_q),
        .idx_i     (paddr_q[AW-2:0]),
        .pwdata_i  (pwdata_q),
        .prdata_o  (prdata2),
        .pready_o  (pready2)
    );
endmodule

// File: tb/tb_apb_modport.sv
// Directed plus randomized bench for apb_modport against a flat
// 512-byte memory model of both slaves.
module tb_apb_modport;
    logic       pclk;
    logic       presetn;
    logic       transfer;
    logic       read_write;
    logic [8:0] apb_write_paddr;
    logic [7:0] apb_write_data;
    logic [8:0] apb_read_paddr;
    logic [7:0] apb_read_data_out;

    logic [7:0] model_mem [512];
    logic [7:0] model_rd;
    int vectors;
    int miscompares;

    typedef struct {
        bit       rd;
        bit [8:0] addr;
        bit [7:0] data;
    } cmd_t;

    apb_modport dut (
        .pclk              (pclk),
        .presetn           (presetn),
        .transfer          (transfer),
        .read_write        (read_write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 512; i++) model_mem[i] = 8'h00;
        model_rd = 8'h00;
    endtask

    task automatic model_apply(input cmd_t c);
        if (c.rd) model_rd = model_mem[c.addr];
        else model_mem[c.addr] = c.data;
    endtask

    task automatic junk();
        read_write      = 1'($urandom);
        apb_write_paddr = 9'($urandom);
        apb_read_paddr  = 9'($urandom);
        apb_write_data  = 8'($urandom);
    endtask

    task automatic drive(input cmd_t c);
        junk();
        transfer   = 1'b1;
        read_write = c.rd;
        if (c.rd) apb_read_paddr = c.addr;
        else apb_write_paddr = c.addr;
        apb_write_data = c.data;
    endtask

    // Single transfer: sampled at edge N, result checked after N+1 and N+2.
    task automatic xfer(input string tag, input bit rd, input bit [8:0] a,
                        input bit [7:0] d);
        cmd_t c;
        c.rd = rd;
        c.addr = a;
        c.data = d;
        drive(c);
        step();
        junk();
        transfer = 1'b0;
        step();
        chk({tag, "_early"}, apb_read_data_out, model_rd);
        junk();
        transfer = 1'b0;
        step();
        model_apply(c);
        chk(tag, apb_read_data_out, model_rd);
    endtask

    // Back-to-back: transfer stays high, one completion every 2 edges.
    task automatic burst(input string tag, input cmd_t q[$]);
        drive(q[0]);
        step();
        for (int i = 0; i < q.size(); i++) begin
            junk();
            transfer = 1'b1;
            step();
            if (i < q.size() - 1) drive(q[i+1]);
            else begin
                junk();
                transfer = 1'b0;
            end
            step();
            model_apply(q[i]);
            chk(tag, apb_read_data_out, model_rd);
        end
    endtask

    initial begin
        cmd_t q[$];
        cmd_t c;
        vectors = 0;
        miscompares = 0;
        presetn = 1'b0;
        transfer = 1'b0;
        read_write = 1'b0;
        apb_write_paddr = '0;
        apb_write_data = '0;
        apb_read_paddr = '0;
        model_reset();
        step();
        step();
        chk("reset_rdata", apb_read_data_out, 8'h00);
        presetn = 1'b1;

        xfer("rd_after_reset", 1'b1, 9'h0C7, 8'h00);
        xfer("wr_005", 1'b0, 9'h005, 8'hA5);
        xfer("rd_005", 1'b1, 9'h005, 8'h00);
        chk("rd_005_val", apb_read_data_out, 8'hA5);
        xfer("wr_105", 1'b0, 9'h105, 8'h3C);
        xfer("iso_rd_005", 1'b1, 9'h005, 8'h00);
        chk("iso_005_val", apb_read_data_out, 8'hA5);
        xfer("iso_rd_105", 1'b1, 9'h105, 8'h00);
        chk("iso_105_val", apb_read_data_out, 8'h3C);

        q = {};
        c = '{rd: 1'b0, addr: 9'h010, data: 8'h11}; q.push_back(c);
        c = '{rd: 1'b0, addr: 9'h011, data: 8'h22}; q.push_back(c);
        c = '{rd: 1'b1, addr: 9'h010, data: 8'h00}; q.push_back(c);
        c = '{rd: 1'b1, addr: 9'h011, data: 8'h00}; q.push_back(c);
        burst("b2b", q);
        chk("b2b_last", apb_read_data_out, 8'h22);

        for (int i = 0; i < 10; i++) begin
            junk();
            transfer = 1'b0;
            step();
            chk("idle_hold", apb_read_data_out, 8'h22);
        end
        xfer("idle_rd_010", 1'b1, 9'h010, 8'h00);
        xfer("idle_rd_105", 1'b1, 9'h105, 8'h00);

        c = '{rd: 1'b0, addr: 9'h020, data: 8'hFF};
        drive(c);
        step();
        presetn = 1'b0;
        transfer = 1'b0;
        step();
        model_reset();
        chk("midrst_rdata", apb_read_data_out, 8'h00);
        presetn = 1'b1;
        xfer("midrst_rd_020", 1'b1, 9'h020, 8'h00);
        xfer("midrst_rd_105", 1'b1, 9'h105, 8'h00);

        for (int i = 0; i < 150; i++) begin
            bit [8:0] a;
            a = 9'($urandom_range(0, 15)) | (9'($urandom_range(0, 1)) << 8);
            if ($urandom_range(0, 7) == 0) a = 9'($urandom);
            xfer("rand", 1'($urandom), a, 8'($urandom));
        end
        for (int b = 0; b < 4; b++) begin
            q = {};
            for (int i = 0; i < 8; i++) begin
                c.rd = 1'($urandom);
                c.addr = 9'($urandom_range(0, 7)) |
                         (9'($urandom_range(0, 1)) << 8);
                c.data = 8'($urandom);
                q.push_back(c);
            end
            burst("rand_b2b", q);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
